// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding, skid sizing and width helper for the FIFO burst reader
package fifo_rd_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry fall-through valid/ready buffer catching FIFO read returns
module rd_skid_buf import fifo_rd_pkg::*; #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [FIFO_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [FIFO_WIDTH-1:0] data_o,
    output logic [OCC_W-1:0]      occ_o,
    output logic [OCC_W-1:0]      occ_nxt_o
);

    logic [FIFO_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]      cnt_q, cnt_d;
    logic                  store, deq;

    // An empty buffer passes the returning word straight through, so the
    // first word is visible in the same cycle the FIFO returns it.
    assign valid_o   = (cnt_q != '0) || push_i;
    assign data_o    = (cnt_q != '0) ? mem_q[rd_ptr_q] : push_data_i;
    assign occ_o     = cnt_q;
    assign occ_nxt_o = cnt_d;

    // Store only words that are not consumed on the fly; dequeue the head on a pop
    always_comb begin
        store    = push_i && !((cnt_q == '0) && pop_i);
        deq      = (cnt_q != '0) && pop_i;
        cnt_d    = cnt_q + OCC_W'(store) - OCC_W'(deq);
        wr_ptr_d = wr_ptr_q ^ store;
        rd_ptr_d = rd_ptr_q ^ deq;
    end

    // Occupancy and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Data storage needs no reset: contents are qualified by the count
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a requested burst from the FIFO onto a valid/ready stream with last marker
module fifo_burst_reader import fifo_rd_pkg::*; #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = len_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  almostempty,
    input  logic                  underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_W-1:0]      words_out
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_q, issue_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             in_flight_q;
    logic             err_q, err_d;
    logic [OCC_W-1:0] occ, occ_nxt;
    logic             accept, uf_hit, push, hs, drained;
    logic             unused_almostempty;

    // empty already reflects the post-read count, so a read at one word
    // left stops the next one without looking at almostempty.
    assign unused_almostempty = almostempty;

    rd_skid_buf #(
        .FIFO_WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(data_out),
        .pop_i      (hs),
        .valid_o    (m_valid),
        .data_o     (m_data),
        .occ_o      (occ),
        .occ_nxt_o  (occ_nxt)
    );

    // Read issue, counters and next-state; an underflowing return is dropped and ends issuing
    always_comb begin
        accept  = (state_q == IDLE) && start && (len != '0) && (len <= LEN_W'(FIFO_DEPTH));
        uf_hit  = in_flight_q && underflow;
        push    = in_flight_q && !underflow;
        hs      = m_valid && m_ready;
        rd_en   = (state_q == READ) && !empty && (issue_q < len_q) && !uf_hit
                  && ((occ + OCC_W'(in_flight_q)) < OCC_W'(SKID_DEPTH));
        len_d   = accept ? len : len_q;
        issue_d = accept ? '0 : issue_q + LEN_W'(rd_en);
        words_d = accept ? '0 : (hs && (words_q != len_q)) ? words_q + LEN_W'(1) : words_q;
        err_d   = !accept && (err_q || uf_hit);
        drained = (occ_nxt == '0) && ((words_d == len_q) || (err_q && !in_flight_q));
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? READ : IDLE;
            READ:    state_d = (uf_hit || (issue_d == len_q)) ? DRAIN : READ;
            DRAIN:   state_d = drained ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset abandons any burst in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_q     <= '0;
            words_q     <= '0;
            in_flight_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_q     <= issue_d;
            words_q     <= words_d;
            in_flight_q <= rd_en;
            err_q       <= err_d;
        end
    end

    assign m_last    = m_valid && (words_q == len_q - LEN_W'(1));
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign err       = err_q;
    assign words_out = words_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed stimulus with a scoreboard checking the burst stream
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        rd_en;
    logic [15:0] data_out = '0;
    logic        empty = 1'b1;
    logic        almostempty = 1'b0;
    logic        underflow = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  words_out;

    fifo_burst_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .empty      (empty),
        .almostempty(almostempty),
        .underflow  (underflow),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fq[$];
    logic [16:0] exp_q[$];
    logic        wr_en = 1'b0;
    logic [15:0] wr_word = '0;
    logic        flush = 1'b0;
    int          force_n = 0;
    int          rd_seen = 0;
    int          outst = 0;
    int          done_cnt = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: 1-cycle read latency, post-edge flags, optional forced underflow
    always @(posedge clk) begin
        underflow <= 1'b0;
        if (flush) fq.delete();
        else begin
            if (rd_en) begin
                rd_seen++;
                if (rd_seen == force_n || fq.size() == 0) underflow <= 1'b1;
                else data_out <= fq.pop_front();
            end
            if (wr_en) fq.push_back(wr_word);
        end
        empty <= (fq.size() == 0);
        almostempty <= (fq.size() == 1);
        outst <= rst ? 0 : outst + int'(rd_en) - int'(m_valid && m_ready) - int'(underflow);
    end

    // Monitor: scoreboard pops on handshake, hold and read-guard checks
    always @(negedge clk) begin
        if (rst) hold_prev = 1'b0;
        else begin
            if (hold_prev) chk("hold", {15'd0, m_valid, m_data}, {15'd0, 1'b1, hold_data});
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            if (rd_en) chk("rd_guard", 32'(outst < 2), 32'd1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got %0h expected no word", m_data);
                end else chk("sb_word", {15'd0, m_last, m_data}, {15'd0, exp_q.pop_front()});
            end
            if (done) done_cnt++;
        end
    end

    task automatic write_word(input logic [15:0] w);
        @(posedge clk); #1 wr_en = 1'b1; wr_word = w;
        @(posedge clk); #1 wr_en = 1'b0;
    endtask

    task automatic go(input logic [3:0] l);
        @(posedge clk); #1 start = 1'b1; len = l;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit toggle);
        bit seen = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (toggle) m_ready = ~m_ready;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_flush;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    logic [7:0] rdv, vv, dv, lv;
    int         r0, d0;

    initial begin
        #3 rst = 1'b1;
        @(negedge clk);
        chk("reset_outs", {21'd0, rd_en, m_valid, m_last, busy, done, err, words_out}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full-rate 4-word burst with cycle-exact timing
        for (int i = 1; i <= 4; i++) write_word(16'h00A0 + 16'(i));
        for (int i = 1; i <= 4; i++) exp_q.push_back({i == 4, 16'h00A0 + 16'(i)});
        @(posedge clk); #1 start = 1'b1; len = 4'd4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rdv[k] = rd_en; vv[k] = m_valid; dv[k] = done; lv[k] = m_last;
            if (k == 0) begin
                @(posedge clk); #1 start = 1'b0;
            end
        end
        chk("t1_rd_en", 32'(rdv), 32'h1E);
        chk("t1_valid", 32'(vv), 32'h3C);
        chk("t1_done", 32'(dv), 32'h40);
        chk("t1_last", 32'(lv), 32'h20);
        chk("t1_words", 32'(words_out), 32'd4);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Backpressure: m_ready toggles every cycle
        for (int i = 1; i <= 3; i++) write_word(16'h00B0 + 16'(i));
        for (int i = 1; i <= 3; i++) exp_q.push_back({i == 3, 16'h00B0 + 16'(i)});
        go(4'd3);
        wait_done(60, 1'b1);
        chk("t2_words", 32'(words_out), 32'd3);
        chk("t2_sb_empty", exp_q.size(), 0);
        @(posedge clk); #1 m_ready = 1'b1;

        // FIFO runs dry mid-burst, later refilled
        write_word(16'h00C1);
        write_word(16'h00C2);
        for (int i = 1; i <= 4; i++) exp_q.push_back({i == 4, 16'h00C0 + 16'(i)});
        r0 = rd_seen;
        d0 = done_cnt;
        go(4'd4);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_rd_stall", rd_seen - r0, 2);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_no_done", done_cnt, d0);
        write_word(16'h00C3);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_rd_resume", rd_seen - r0, 3);
        chk("t3_busy2", 32'(busy), 32'd1);
        chk("t3_no_done2", done_cnt, d0);
        write_word(16'h00C4);
        wait_done(20, 1'b0);
        chk("t3_words", 32'(words_out), 32'd4);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Underflow on the second read
        for (int i = 1; i <= 4; i++) write_word(16'h00D0 + 16'(i));
        exp_q.push_back({1'b0, 16'h00D1});
        force_n = rd_seen + 2;
        go(4'd4);
        wait_done(20, 1'b0);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_words", 32'(words_out), 32'd1);
        chk("t4_sb_empty", exp_q.size(), 0);
        force_n = 0;
        do_flush;

        // Reset mid-burst with a word held in the buffer
        for (int i = 1; i <= 3; i++) write_word(16'h00E0 + 16'(i));
        m_ready = 1'b0;
        go(4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("t5_rst_outs", {21'd0, rd_en, m_valid, m_last, busy, done, err, words_out}, 32'd0);
        @(posedge clk); #1 rst = 1'b0; flush = 1'b0; m_ready = 1'b1;
        write_word(16'h00F1);
        write_word(16'h00F2);
        exp_q.push_back({1'b0, 16'h00F1});
        exp_q.push_back({1'b1, 16'h00F2});
        go(4'd2);
        wait_done(20, 1'b0);
        chk("t5_words", 32'(words_out), 32'd2);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Out-of-range lengths are ignored
        write_word(16'h0071);
        r0 = rd_seen;
        go(4'd0);
        chk("t6_busy_len0", 32'(busy), 32'd0);
        go(4'd9);
        chk("t6_busy_len9", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy_idle", 32'(busy), 32'd0);
        chk("t6_no_rd", rd_seen - r0, 0);
        do_flush;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
